pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_CYCLES, default 1: number of load-use stall cycles per hazard, legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 idex_memread_i  input  1  instruction in ID/EX is a load.
REQ-006 idex_rt_i  input  5  load destination register in ID/EX.
REQ-007 ifid_rs_i, ifid_rt_i  input  5 each  source registers of the instruction in IF/ID.
REQ-008 branch_taken_i  input  1  branch/jump resolved taken this cycle.
REQ-009 imem_stall_i  input  1  instruction memory not ready.
REQ-010 dmem_stall_i  input  1  data memory busy.
REQ-011 pc_write_o  output  1  PC update enable.
REQ-012 redirect_o  output  1  PC mux selects the branch target.
REQ-013 ifid_hold_o  output  1  IF/ID keeps its contents.
REQ-014 ifid_flush_o  output  1  IF/ID instruction cleared to 32'b0, address still written.
REQ-015 idex_bubble_o  output  1  ID/EX control fields zeroed.
REQ-016 pipe_freeze_o  output  1  PC, IF/ID, ID/EX and EX/MEM all hold.
REQ-017 state_o  output  2  current state: RUN=0, LU_STALL=1, MEM_WAIT=2.
REQ-018 stall_cnt_o, flush_cnt_o  output  CNT_W each  performance counters.

Function
REQ-019 lu_hit SHALL be idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || idex_rt_i==ifid_rt_i).
REQ-020 Control outputs SHALL be combinational from the current state, the flush_pend flag and the inputs, so they take effect in the same cycle.
REQ-021 Any output not asserted by a rule below SHALL be 0, except pc_write_o, which SHALL be 1.
REQ-022 RUN priority: dmem_stall_i > branch_taken_i > lu_hit > imem_stall_i.
REQ-023 RUN with dmem_stall_i=1: pipe_freeze_o=1, ifid_hold_o=1, pc_write_o=0; next state MEM_WAIT; flush_pend is set if branch_taken_i=1 in that cycle.
REQ-024 RUN with branch_taken_i=1: redirect_o=1, ifid_flush_o=1, pc_write_o=1; lu_hit is ignored; next state RUN.
REQ-025 RUN with lu_hit=1: pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1; next state LU_STALL if LU_CYCLES>1, otherwise RUN; lu_cnt is loaded with 1.
REQ-026 RUN with imem_stall_i=1 only: pc_write_o=0, ifid_flush_o=1.
REQ-027 LU_STALL: same outputs as REQ-025; lu_cnt increments each cycle; the state returns to RUN in the cycle lu_cnt reaches LU_CYCLES-1.
REQ-028 LU_STALL with dmem_stall_i=1: REQ-023 applies instead, and the remaining load-use cycles are abandoned.
REQ-029 MEM_WAIT with dmem_stall_i=1: outputs as in REQ-023, and branch_taken_i is ignored.
REQ-030 MEM_WAIT with dmem_stall_i=0 (exit cycle): outputs as in RUN, except that if flush_pend=1 the REQ-024 outputs are forced; flush_pend clears; next state follows the RUN rules.
REQ-031 stall_cnt_o SHALL increment in every cycle where pc_write_o=0 and rst_i=0, saturating at 2^CNT_W-1.
REQ-032 flush_cnt_o SHALL increment in every cycle where redirect_o=1, saturating at 2^CNT_W-1.
REQ-033 state_o encoding 3 SHALL never occur; if it does, the next state SHALL be RUN.

Reset
REQ-034 While rst_i=1: pc_write_o=0, ifid_flush_o=1, idex_bubble_o=1, all other control outputs 0.
REQ-035 On a rising edge with rst_i=1: state becomes RUN, and lu_cnt, flush_pend and both counters become 0.
REQ-036 Reset asserted during LU_STALL or MEM_WAIT SHALL discard the pending stall or flush.

Verification
REQ-037 Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5, LU_CYCLES=1 -> one cycle with pc_write_o=0, ifid_hold_o=1, idex_bubble_o=1; stall_cnt_o=1.
REQ-038 Load with rt=0 matching ifid_rs_i=0 -> no stall; pc_write_o=1.
REQ-039 Branch and lu_hit in the same cycle -> redirect_o=1, ifid_flush_o=1, no bubble; flush_cnt_o=1.
REQ-040 dmem_stall_i high for 3 cycles, with branch_taken_i=1 in the first cycle -> pipe_freeze_o=1 for 3 cycles, then the exit cycle has redirect_o=1 and ifid_flush_o=1; stall_cnt_o=3.
REQ-041 LU_CYCLES=3 with lu_hit -> state_o sequence 0,1,1 then 0; 3 bubble cycles.
REQ-042 rst_i pulsed during MEM_WAIT with flush_pend=1 -> state_o=0, no redirect after reset; counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-wait freeze.
// Controls are combinational (same cycle). Stall/flush counters are registered and saturate.
module pipe_hazard_ctrl #(
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             imem_stall_i,
  input  logic             dmem_stall_i,
  output logic             pc_write_o,
  output logic             redirect_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [3:0] LU_LAST = 4'(LU_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_lu_cnt;
  logic             r_flush_pend;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lu_hit;
  logic w_eff_br;

  assign w_lu_hit = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  // A branch that arrived while memory froze the pipe is replayed on the exit cycle.
  assign w_eff_br = branch_taken_i || ((r_state == MEM_WAIT) && r_flush_pend);

  always_comb begin
    pc_write_o    = 1'b1;
    redirect_o    = 1'b0;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (dmem_stall_i) begin
            pipe_freeze_o = 1'b1;
            ifid_hold_o   = 1'b1;
            pc_write_o    = 1'b0;
          end else if (w_eff_br) begin
            redirect_o    = 1'b1;
            ifid_flush_o  = 1'b1;
          end else if (w_lu_hit) begin
            pc_write_o    = 1'b0;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
          end else if (imem_stall_i) begin
            pc_write_o    = 1'b0;
            ifid_flush_o  = 1'b1;
          end
        end
        LU_STALL: begin
          if (dmem_stall_i) begin
            pipe_freeze_o = 1'b1;
            ifid_hold_o   = 1'b1;
            pc_write_o    = 1'b0;
          end else begin
            pc_write_o    = 1'b0;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
          end
        end
        default: begin
          pc_write_o = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= RUN;
      r_lu_cnt     <= 4'd0;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (!pc_write_o && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (redirect_o && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;

      case (r_state)
        RUN, MEM_WAIT: begin
          if (dmem_stall_i) begin
            r_state <= MEM_WAIT;
            if (r_state == RUN)
              r_flush_pend <= branch_taken_i;
          end else begin
            r_flush_pend <= 1'b0;
            if (w_eff_br) begin
              r_state <= RUN;
            end else if (w_lu_hit) begin
              r_lu_cnt <= 4'd1;
              r_state  <= (LU_CYCLES > 1) ? LU_STALL : RUN;
            end else begin
              r_state <= RUN;
            end
          end
        end
        LU_STALL: begin
          if (dmem_stall_i) begin
            r_state      <= MEM_WAIT;
            r_flush_pend <= branch_taken_i;
          end else begin
            r_lu_cnt <= r_lu_cnt + 4'd1;
            if (r_lu_cnt == LU_LAST)
              r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LU_CYCLES=1 with 4-bit counters, LU_CYCLES=3 with 16-bit).
// Directed scenarios plus a randomized run against an action-level reference model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       memread;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       br;
  logic       imem;
  logic       dmem;

  logic        pcw0, red0, hold0, fl0, bub0, frz0;
  logic        pcw1, red1, hold1, fl1, bub1, frz1;
  logic [1:0]  st0, st1;
  logic [3:0]  sc0, fc0;
  logic [15:0] sc1, fc1;

  logic [5:0] ctl [2];
  logic [1:0] st  [2];
  int         sc  [2];
  int         fc  [2];

  int n_checks = 0;
  int n_fail   = 0;

  int lu_len [2] = '{1, 3};
  int sat    [2] = '{15, 65535};
  int m_mode [2];
  int m_left [2];
  int m_stall[2];
  int m_flush[2];
  bit m_pend [2];

  localparam int A_RESET = 0, A_FREEZE = 1, A_REDIR = 2, A_LOAD = 3, A_FBUB = 4, A_NORM = 5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_CYCLES(1), .CNT_W(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .branch_taken_i(br),
    .imem_stall_i(imem), .dmem_stall_i(dmem),
    .pc_write_o(pcw0), .redirect_o(red0), .ifid_hold_o(hold0), .ifid_flush_o(fl0),
    .idex_bubble_o(bub0), .pipe_freeze_o(frz0), .state_o(st0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  pipe_hazard_ctrl #(.LU_CYCLES(3), .CNT_W(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .branch_taken_i(br),
    .imem_stall_i(imem), .dmem_stall_i(dmem),
    .pc_write_o(pcw1), .redirect_o(red1), .ifid_hold_o(hold1), .ifid_flush_o(fl1),
    .idex_bubble_o(bub1), .pipe_freeze_o(frz1), .state_o(st1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  // ctl bit order: {pc_write, redirect, hold, flush, bubble, freeze}
  assign ctl[0] = {pcw0, red0, hold0, fl0, bub0, frz0};
  assign ctl[1] = {pcw1, red1, hold1, fl1, bub1, frz1};
  assign st[0]  = st0;
  assign st[1]  = st1;
  assign sc[0]  = {28'd0, sc0};
  assign sc[1]  = {16'd0, sc1};
  assign fc[0]  = {28'd0, fc0};
  assign fc[1]  = {16'd0, fc1};

  task automatic drive_idle();
    memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    br = 1'b0; imem = 1'b0; dmem = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; drive_idle(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [5:0] ctl_of(int act);
    case (act)
      A_RESET:  return 6'b000110;
      A_FREEZE: return 6'b001001;
      A_REDIR:  return 6'b110100;
      A_LOAD:   return 6'b001010;
      A_FBUB:   return 6'b000100;
      default:  return 6'b100000;
    endcase
  endfunction

  function automatic int action_of(int k);
    bit hit;
    bit eff_br;
    hit = memread && (idex_rt != 5'd0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    if (rst) return A_RESET;
    if (dmem) return A_FREEZE;
    if (m_mode[k] == 1) return A_LOAD;
    eff_br = br || (m_mode[k] == 2 && m_pend[k]);
    if (eff_br) return A_REDIR;
    if (hit) return A_LOAD;
    if (imem) return A_FBUB;
    return A_NORM;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd1;
    br = 1'b1; imem = 1'b1; dmem = 1'b0;
    settle();
    n_checks++;
    if (ctl[0] !== 6'b000110) begin
      n_fail++; $display("FAIL reset_ctl0 got %b exp %b", ctl[0], 6'b000110);
    end
    n_checks++;
    if (ctl[1] !== 6'b000110) begin
      n_fail++; $display("FAIL reset_ctl1 got %b exp %b", ctl[1], 6'b000110);
    end
    tick();
    n_checks++;
    if (st0 !== 2'd0 || st1 !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got %0d/%0d exp 0/0", st0, st1);
    end
    n_checks++;
    if (sc[0] !== 0 || fc[0] !== 0 || sc[1] !== 0 || fc[1] !== 0) begin
      n_fail++; $display("FAIL reset_cnt got %0d %0d %0d %0d exp 0", sc[0], fc[0], sc[1], fc[1]);
    end
    rst = 1'b0;
    drive_idle();
    settle();
    n_checks++;
    if (ctl[0] !== 6'b100000) begin
      n_fail++; $display("FAIL idle_ctl0 got %b exp %b", ctl[0], 6'b100000);
    end
    tick();
  endtask

  task automatic test_load_use();
    pulse_reset();
    memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
    settle();
    n_checks++;
    if (pcw0 !== 1'b0 || hold0 !== 1'b1 || bub0 !== 1'b1) begin
      n_fail++; $display("FAIL lu_ctl0 got pcw=%b hold=%b bub=%b exp 0 1 1", pcw0, hold0, bub0);
    end
    n_checks++;
    if (st1 !== 2'd0 || bub1 !== 1'b1) begin
      n_fail++; $display("FAIL lu3_c0 got st=%0d bub=%b exp 0 1", st1, bub1);
    end
    tick();
    drive_idle();
    settle();
    n_checks++;
    if (pcw0 !== 1'b1 || sc[0] !== 1) begin
      n_fail++; $display("FAIL lu_after0 got pcw=%b stall=%0d exp 1 1", pcw0, sc[0]);
    end
    n_checks++;
    if (st1 !== 2'd1 || bub1 !== 1'b1) begin
      n_fail++; $display("FAIL lu3_c1 got st=%0d bub=%b exp 1 1", st1, bub1);
    end
    tick();
    n_checks++;
    if (st1 !== 2'd1 || bub1 !== 1'b1) begin
      n_fail++; $display("FAIL lu3_c2 got st=%0d bub=%b exp 1 1", st1, bub1);
    end
    tick();
    n_checks++;
    if (st1 !== 2'd0 || bub1 !== 1'b0 || sc[1] !== 3) begin
      n_fail++; $display("FAIL lu3_end got st=%0d bub=%b stall=%0d exp 0 0 3", st1, bub1, sc[1]);
    end
    tick();
  endtask

  task automatic test_rt_zero();
    memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    settle();
    n_checks++;
    if (pcw0 !== 1'b1 || pcw1 !== 1'b1 || bub0 !== 1'b0) begin
      n_fail++; $display("FAIL rt_zero got pcw=%b/%b bub=%b exp 1/1 0", pcw0, pcw1, bub0);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_branch_lu();
    pulse_reset();
    memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd1; ifid_rt = 5'd3; br = 1'b1;
    settle();
    n_checks++;
    if (red0 !== 1'b1 || fl0 !== 1'b1 || bub0 !== 1'b0 || hold0 !== 1'b0) begin
      n_fail++; $display("FAIL br_lu got red=%b fl=%b bub=%b hold=%b exp 1 1 0 0", red0, fl0, bub0, hold0);
    end
    tick();
    drive_idle();
    settle();
    n_checks++;
    if (fc[0] !== 1 || st1 !== 2'd0) begin
      n_fail++; $display("FAIL br_lu_cnt got flush=%0d st1=%0d exp 1 0", fc[0], st1);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      dmem = 1'b1; br = (c == 0);
      settle();
      n_checks++;
      if (frz0 !== 1'b1 || pcw0 !== 1'b0 || hold0 !== 1'b1 || red0 !== 1'b0) begin
        n_fail++; $display("FAIL memwait_c%0d got frz=%b pcw=%b hold=%b red=%b exp 1 0 1 0", c, frz0, pcw0, hold0, red0);
      end
      tick();
      n_checks++;
      if (st0 !== 2'd2) begin
        n_fail++; $display("FAIL memwait_st_c%0d got %0d exp 2", c, st0);
      end
    end
    drive_idle();
    settle();
    n_checks++;
    if (red0 !== 1'b1 || fl0 !== 1'b1 || frz0 !== 1'b0 || pcw0 !== 1'b1) begin
      n_fail++; $display("FAIL memwait_exit got red=%b fl=%b frz=%b pcw=%b exp 1 1 0 1", red0, fl0, frz0, pcw0);
    end
    tick();
    n_checks++;
    if (sc[0] !== 3 || fc[0] !== 1 || st0 !== 2'd0) begin
      n_fail++; $display("FAIL memwait_cnt got stall=%0d flush=%0d st=%0d exp 3 1 0", sc[0], fc[0], st0);
    end
  endtask

  task automatic test_reset_mem_wait();
    pulse_reset();
    dmem = 1'b1; br = 1'b1; tick();
    br = 1'b0; tick();
    rst = 1'b1; dmem = 1'b0;
    settle();
    n_checks++;
    if (red0 !== 1'b0 || ctl[0] !== 6'b000110) begin
      n_fail++; $display("FAIL rst_mw_ctl got %b exp %b", ctl[0], 6'b000110);
    end
    tick();
    rst = 1'b0;
    settle();
    n_checks++;
    if (red0 !== 1'b0 || red1 !== 1'b0 || st0 !== 2'd0 || st1 !== 2'd0) begin
      n_fail++; $display("FAIL rst_mw_after got red=%b/%b st=%0d/%0d exp 0/0 0/0", red0, red1, st0, st1);
    end
    n_checks++;
    if (sc[0] !== 0 || fc[0] !== 0 || sc[1] !== 0 || fc[1] !== 0) begin
      n_fail++; $display("FAIL rst_mw_cnt got %0d %0d %0d %0d exp 0", sc[0], fc[0], sc[1], fc[1]);
    end
    tick();
  endtask

  task automatic test_random();
    int act;
    logic [5:0] exp_ctl;
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_pend[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst     = ($urandom_range(0, 99) < 2);
      dmem    = ($urandom_range(0, 99) < 20);
      br      = ($urandom_range(0, 99) < 20);
      imem    = ($urandom_range(0, 99) < 20);
      memread = ($urandom_range(0, 99) < 50);
      idex_rt = 5'($urandom_range(0, 3));
      ifid_rs = 5'($urandom_range(0, 3));
      ifid_rt = 5'($urandom_range(0, 3));
      settle();
      for (int k = 0; k < 2; k++) begin
        act = action_of(k);
        exp_ctl = ctl_of(act);
        n_checks++;
        if (ctl[k] !== exp_ctl) begin
          n_fail++; $display("FAIL rand_ctl inst%0d cyc%0d got %b exp %b", k, cyc, ctl[k], exp_ctl);
        end
        n_checks++;
        if (st[k] !== 2'(m_mode[k]) || sc[k] !== m_stall[k] || fc[k] !== m_flush[k]) begin
          n_fail++;
          $display("FAIL rand_reg inst%0d cyc%0d got st=%0d stall=%0d flush=%0d exp %0d %0d %0d",
                   k, cyc, st[k], sc[k], fc[k], m_mode[k], m_stall[k], m_flush[k]);
        end
        if (act == A_RESET) begin
          m_mode[k] = 0; m_left[k] = 0; m_pend[k] = 1'b0; m_stall[k] = 0; m_flush[k] = 0;
        end else begin
          if (!exp_ctl[5] && m_stall[k] < sat[k]) m_stall[k]++;
          if (exp_ctl[4] && m_flush[k] < sat[k]) m_flush[k]++;
          case (act)
            A_FREEZE: begin
              if (m_mode[k] != 2) m_pend[k] = br;
              m_mode[k] = 2;
            end
            A_LOAD: begin
              if (m_mode[k] == 1) begin
                m_left[k]--;
                if (m_left[k] == 0) m_mode[k] = 0;
              end else begin
                m_pend[k] = 1'b0;
                m_left[k] = lu_len[k] - 1;
                m_mode[k] = (m_left[k] > 0) ? 1 : 0;
              end
            end
            default: begin
              m_mode[k] = 0;
              m_pend[k] = 1'b0;
            end
          endcase
        end
      end
      tick();
    end
    rst = 1'b0;
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_rt_zero();
    test_branch_lu();
    test_mem_wait();
    test_reset_mem_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
